// File: rtl/bcd_entry_display_if.sv
// Keypad-to-entry-register bus: encoder inputs and control go in, digits and display come out.
interface bcd_entry_display_if #(
  parameter int unsigned NDIG = 4
);
  logic [3:0]        D;
  logic              valid;
  logic              load_en;
  logic              clear;
  logic [4*NDIG-1:0] digits;
  logic [2:0]        count;
  logic              full;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;

  modport master (
    output D, valid, load_en, clear,
    input  digits, count, full, seg, an
  );

  modport slave (
    input  D, valid, load_en, clear,
    output digits, count, full, seg, an
  );
endinterface

// File: rtl/bcd_entry_display.sv
// Debounces keypad presses, shifts accepted BCD digits into an entry register
// and drives a time-multiplexed seven-segment display from that register.
module bcd_entry_display #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic                clk,
  input  logic                resetn,
  bcd_entry_display_if.slave  bus
);

  localparam int unsigned HW = $clog2(DEBOUNCE + 1);
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StHeld} press_state_e;

  press_state_e      r_state, w_state_next;
  logic [HW-1:0]     r_hold, w_hold_next, w_hold_inc;
  logic              w_accept;

  logic [4*NDIG-1:0] r_digits, w_shift;
  logic [2:0]        r_count;
  logic              r_full;
  logic              w_load;

  logic [DW-1:0]     r_div;
  logic [IW-1:0]     r_idx, w_idx_next;
  logic              w_wrap;
  logic [3:0]        w_sel_digit;
  logic [6:0]        r_seg, w_seg_next;
  logic [NDIG-1:0]   r_an, w_an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Press FSM: one accept per press, after DEBOUNCE consecutive high samples.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_hold_inc   = r_hold + HW'(1);
    w_accept     = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.valid) begin
          w_hold_next = HW'(1);
          if (DEBOUNCE == 1) begin
            w_accept     = 1'b1;
            w_state_next = StHeld;
          end else begin
            w_state_next = StArm;
          end
        end
      end
      StArm: begin
        if (bus.valid) begin
          w_hold_next = w_hold_inc;
          if (w_hold_inc == HW'(DEBOUNCE)) begin
            w_accept     = 1'b1;
            w_state_next = StHeld;
          end
        end else begin
          w_state_next = StIdle;
        end
      end
      StHeld: begin
        if (!bus.valid) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
    end
  end

  // Accepts that are non-decimal, disabled or overflowing are silently dropped.
  always_comb begin
    w_load  = w_accept & bus.load_en & (bus.D <= 4'd9) & (r_count < 3'(NDIG));
    w_shift = (4*NDIG)'({r_digits, bus.D});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_digits <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (bus.clear) begin
      r_digits <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (w_load) begin
      r_digits <= w_shift;
      r_count  <= r_count + 3'd1;
      r_full   <= ((r_count + 3'd1) == 3'(NDIG));
    end
  end

  // Display scan: seg/an are registered for the index being moved to.
  always_comb begin
    w_wrap      = (r_div == DW'(SCAN_DIV - 1));
    w_idx_next  = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
    w_sel_digit = r_digits[4*w_idx_next +: 4];
    w_an_next   = ~(NDIG'(1) << w_idx_next);
    w_seg_next  = 7'h00;
    if (8'(w_idx_next) < 8'(r_count)) w_seg_next = seg_decode(w_sel_digit);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
      r_idx <= '0;
      r_seg <= '0;
      r_an  <= '1;
    end else if (w_wrap) begin
      r_div <= '0;
      r_idx <= w_idx_next;
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign bus.digits = r_digits;
  assign bus.count  = r_count;
  assign bus.full   = r_full;
  assign bus.seg    = r_seg;
  assign bus.an     = r_an;

endmodule

// File: tb/tb_bcd_entry_display.sv
// Bench for bcd_entry_display: table of key presses with expected register state,
// plus hand sequences for scan rotation, clear priority, held keys and async reset.
module tb_bcd_entry_display;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 2;

  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  typedef struct {
    logic [3:0]  d;
    int          hi;
    logic        le;
    logic [15:0] exp_digits;
    logic [2:0]  exp_count;
    logic        exp_full;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [2:0]  count;
    logic        full;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bcd_entry_display_if #(.NDIG(NDIG)) bus ();

  bcd_entry_display #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  vec_t        vecs [10];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] cur_digits = '0;
  logic [2:0]  cur_count  = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [2:0] c, input logic f);
    exp_t e;
    e.digits = d;
    e.count  = c;
    e.full   = f;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(name, {12'd0, bus.digits, bus.count, bus.full}, {12'd0, e.digits, e.count, e.full});
      cur_digits = e.digits;
      cur_count  = e.count;
    end
  endtask

  task automatic press(input logic [3:0] d, input int hi, input int lo);
    bus.D     = d;
    bus.valid = 1'b1;
    repeat (hi) step();
    bus.valid = 1'b0;
    repeat (lo) step();
  endtask

  task automatic apply_vec(input int i);
    bus.load_en = vecs[i].le;
    push_exp(vecs[i].exp_digits, vecs[i].exp_count, vecs[i].exp_full);
    press(vecs[i].d, vecs[i].hi, 3);
    pop_compare($sformatf("vec%0d", i));
  endtask

  // Flush one rotation, then check every cycle of the next against the bench model.
  task automatic scan_check(input string name, output logic seen_lo, output logic seen_hi);
    int idx;
    logic [6:0] exp_seg;
    seen_lo = 1'b0;
    seen_hi = 1'b0;
    repeat (NDIG * SCAN_DIV) step();
    for (int c = 0; c < int'(NDIG * SCAN_DIV); c++) begin
      step();
      idx = -1;
      for (int b = 0; b < int'(NDIG); b++) begin
        if (bus.an == ~(4'(1) << b)) idx = b;
      end
      check($sformatf("%s_an_onehot0_c%0d", name, c), {31'd0, idx >= 0}, 32'd1);
      if (idx < 0) idx = 0;
      exp_seg = (idx < int'(cur_count)) ? DEC[cur_digits[4*idx +: 4]] : 7'h00;
      check($sformatf("%s_seg_c%0d", name, c), {25'd0, bus.seg}, {25'd0, exp_seg});
      if (bus.an == 4'b1110 && bus.seg == 7'h66) seen_lo = 1'b1;
      if (bus.an == 4'b0111 && bus.seg == 7'h06) seen_hi = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic seen_lo, seen_hi;
    int   n;

    vecs[0] = '{4'd1,  5,  1'b1, 16'h0001, 3'd1, 1'b0};
    vecs[1] = '{4'd2,  5,  1'b1, 16'h0012, 3'd2, 1'b0};
    vecs[2] = '{4'd3,  5,  1'b1, 16'h0123, 3'd3, 1'b0};
    vecs[3] = '{4'd4,  5,  1'b1, 16'h1234, 3'd4, 1'b1};
    vecs[4] = '{4'd5,  5,  1'b1, 16'h1234, 3'd4, 1'b1};
    vecs[5] = '{4'd7,  1,  1'b1, 16'h0000, 3'd0, 1'b0};
    vecs[6] = '{4'd7,  20, 1'b1, 16'h0007, 3'd1, 1'b0};
    vecs[7] = '{4'hA,  5,  1'b1, 16'h0007, 3'd1, 1'b0};
    vecs[8] = '{4'd3,  5,  1'b0, 16'h0007, 3'd1, 1'b0};
    vecs[9] = '{4'd8,  2,  1'b1, 16'h0078, 3'd2, 1'b0};

    resetn      = 1'b0;
    bus.D       = 4'd0;
    bus.valid   = 1'b0;
    bus.load_en = 1'b0;
    bus.clear   = 1'b0;
    repeat (3) step();
    check("rst_digits", {16'd0, bus.digits}, 32'd0);
    check("rst_count",  {29'd0, bus.count},  32'd0);
    check("rst_full",   {31'd0, bus.full},   32'd0);
    check("rst_seg",    {25'd0, bus.seg},    32'd0);
    check("rst_an",     {28'd0, bus.an},     32'hF);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) apply_vec(i);
    scan_check("scan1234", seen_lo, seen_hi);
    check("scan_an1110_seg66", {31'd0, seen_lo}, 32'd1);
    check("scan_an0111_seg06", {31'd0, seen_hi}, 32'd1);
    apply_vec(4);

    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    push_exp(16'h0000, 3'd0, 1'b0);
    pop_compare("clear");

    for (int i = 5; i < 10; i++) apply_vec(i);

    // Key held while load_en rises must not load until re-pressed.
    bus.load_en = 1'b0;
    bus.D       = 4'd5;
    bus.valid   = 1'b1;
    repeat (4) step();
    bus.load_en = 1'b1;
    repeat (4) step();
    push_exp(16'h0078, 3'd2, 1'b0);
    pop_compare("held_le_rise");
    bus.valid = 1'b0;
    repeat (3) step();
    push_exp(16'h0785, 3'd3, 1'b0);
    press(4'd5, 5, 3);
    pop_compare("repress");

    // Clear lands on the same edge as the accept of 9.
    bus.D     = 4'd9;
    bus.valid = 1'b1;
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.valid = 1'b0;
    push_exp(16'h0000, 3'd0, 1'b0);
    pop_compare("clear_vs_accept");
    repeat (3) step();
    scan_check("blank", seen_lo, seen_hi);

    // Async reset in the middle of a press and a scan period.
    push_exp(16'h0003, 3'd1, 1'b0);
    press(4'd3, 5, 3);
    pop_compare("pre_reset_load");
    repeat (5) step();
    bus.D     = 4'd6;
    bus.valid = 1'b1;
    step();
    #2 resetn = 1'b0;
    #1;
    check("midrst_digits", {16'd0, bus.digits}, 32'd0);
    check("midrst_count",  {29'd0, bus.count},  32'd0);
    check("midrst_full",   {31'd0, bus.full},   32'd0);
    check("midrst_seg",    {25'd0, bus.seg},    32'd0);
    check("midrst_an",     {28'd0, bus.an},     32'hF);
    @(posedge clk);
    #1 resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      if (bus.an != 4'hF) break;
    end
    check("first_an_edge", n, SCAN_DIV);
    check("first_an",      {28'd0, bus.an},  32'b1101);
    check("first_seg",     {25'd0, bus.seg}, 32'd0);
    bus.valid = 1'b0;
    repeat (3) step();
    push_exp(16'h0006, 3'd1, 1'b0);
    pop_compare("held_after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_entry_display.md
Name: bcd_entry_display

Overview:
Consumer side of the keypad BCD encoder in the microwave front panel. Takes the encoder's 4-bit BCD code and valid flag and debounces each key press. Each accepted press shifts one digit into an NDIG-digit time-entry register. The register is decoded to seven-segment patterns and shown on a time-multiplexed display; the register is also exported to the timer/control logic.

Parameters:
NDIG, 4, number of BCD digits held and displayed (digit 0 = least significant, rightmost)
SCAN_DIV, 4, clock cycles each display digit stays selected (>=1)
DEBOUNCE, 2, consecutive sampled-high cycles of valid required to accept a press (>=1)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
D  input  4  BCD code from keypad encoder
valid  input  1  encoder valid, high while a key is pressed
load_en  input  1  high = presses may load digits
clear  input  1  synchronous clear of entry register
digits  output  4*NDIG  entered digits, digit i at bits [4i+3:4i]
count  output  3  number of digits entered, 0..NDIG
full  output  1  high when count == NDIG
seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high
an  output  NDIG  digit select, active-low, one-hot-zero

Behaviour:
- Reset (resetn low, async): digits=0, count=0, full=0, seg=0, an=all ones, press FSM=IDLE, scan divider=0, scan index=0.
- Press FSM, samples valid on every rising edge:
  - IDLE: valid=1 -> ARM with hold counter=1; if DEBOUNCE==1, accept on this edge and go to HELD.
  - ARM: valid=1 -> increment counter; when the counter reaches DEBOUNCE, accept on that edge and go to HELD. valid=0 -> IDLE, no accept.
  - HELD: stay while valid=1; valid=0 -> IDLE.
  - Exactly one accept per press, however long the key is held.
  - With DEBOUNCE=2, a press first sampled at edge k is accepted at edge k+1. D is sampled at the accept edge; digits/count are visible after that edge.
- On accept, digits load only if load_en=1 AND D<=9 AND count<NDIG:
  - digits <= {digits[4*NDIG-5:0], D}
  - count <= count+1
  - Otherwise the accept is discarded: no change, no error flag.
  - The FSM runs regardless of load_en. A key held while load_en rises does not load until it is released and pressed again.
- full = (count==NDIG), registered together with count.
- clear=1 at an edge: digits=0, count=0, full=0. clear has priority over a simultaneous accept (the digit is lost). The press FSM is not reset by clear.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On the edge where it wraps, scan index <= (index+1) mod NDIG, and seg/an are registered for the new index.
  - an = ~(1<<index).
  - seg = decode(digit[index]) if index < count, else 0 (blank unentered leading positions; all blank when count=0).
  - First display update occurs on edge SCAN_DIV after reset release, showing index 1 (index 0 follows after a full cycle).
- Decode, gfedcba hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Codes 10-15 give 00 (never stored, but decode is total).
- Reset asserted mid-press or mid-scan: everything returns to reset values immediately. A key still held after release of reset is seen by IDLE as a new press.

Test Plan:
- Reset, then press keys 1,2,3,4 (valid high 5 cycles, low 3 each) -> digits=16'h1234, count=4, full=1; the scan presents an=1110 with seg=66, and an=0111 with seg=06 in rotation.
- Fifth press D=5 with full=1 -> digits stay 16'h1234, count stays 4.
- valid high for 1 cycle only (DEBOUNCE=2) -> no load. valid held 20 cycles with D=7 -> exactly one load, digits=16'h0007, count=1.
- D=4'hA pressed, and a press with load_en=0 -> both ignored. Key held while load_en 0->1 -> no load until re-press.
- clear asserted on the same edge as an accept of D=9 after entering 5 -> digits=0, count=0, full=0, all an positions show seg=0.
- resetn pulsed low mid-press and mid-scan -> immediately digits=0, count=0, seg=0, an=1111. After release, the first an change occurs SCAN_DIV edges later with an=1101.
